// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and error codes for the UART frame loader
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_DATA_H,
        ST_DATA_L,
        ST_CHK
    } state_t;
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CHK     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;
endpackage

// File: rtl/uart_frame_loader.sv
// uart_frame_loader: parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte stream into 16-bit memory writes
//   clk, rst_n          : clock, synchronous active-low reset
//   rx_data, rx_data_ready, rx_endofpacket : byte stream and line-idle pulse from the UART receiver
//   mem_we, mem_ready, mem_addr, mem_wdata : valid/ready word write port
//   busy, frame_done, frame_error, err_code : frame status
module uart_frame_loader
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_ready,
    input  logic        rx_endofpacket,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_error,
    output logic [1:0]  err_code
);
    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_sum;
    logic [15:0] r_addr;
    logic [7:0]  r_len;
    logic [7:0]  r_hi;
    logic        r_mem_we;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_frame_done;
    logic        r_frame_error;
    logic [1:0]  r_err_code;
    logic [7:0]  w_sum;
    logic        w_rx;
    logic        w_overrun;
    logic        w_load;
    logic        w_done;
    logic        w_err;
    logic [1:0]  w_code;

    // an end-of-packet in the same cycle discards the byte
    assign w_rx      = rx_data_ready && !rx_endofpacket;
    assign w_sum     = r_sum + rx_data;
    // a pending write retiring this very cycle frees the slot for the new word
    assign w_overrun = r_mem_we && !mem_ready;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_code       = r_err_code;
        if (rx_endofpacket) begin
            if (r_state != ST_IDLE) begin
                w_state_next = ST_IDLE;
                w_err        = 1'b1;
                w_code       = ERR_TIMEOUT;
            end
        end else if (rx_data_ready) begin
            case (r_state)
                ST_IDLE:   w_state_next = (rx_data == SYNC_BYTE) ? ST_ADDR_H : ST_IDLE;
                ST_ADDR_H: w_state_next = ST_ADDR_L;
                ST_ADDR_L: w_state_next = ST_LEN;
                ST_LEN:    w_state_next = (rx_data == 8'd0) ? ST_CHK : ST_DATA_H;
                ST_DATA_H: w_state_next = ST_DATA_L;
                ST_DATA_L: begin
                    if (w_overrun) begin
                        w_state_next = ST_IDLE;
                        w_err        = 1'b1;
                        w_code       = ERR_OVERRUN;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = (r_len == 8'd1) ? ST_CHK : ST_DATA_H;
                    end
                end
                ST_CHK: begin
                    w_state_next = ST_IDLE;
                    w_done       = (w_sum == 8'd0);
                    w_err        = (w_sum != 8'd0);
                    w_code       = (w_sum == 8'd0) ? ERR_NONE : ERR_CHK;
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum         <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_hi          <= '0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_frame_done  <= w_done;
            r_frame_error <= w_err;
            r_err_code    <= w_code;
            if (w_rx) begin
                r_sum <= (r_state == ST_IDLE) ? 8'd0 : w_sum;
                if (r_state == ST_ADDR_H) r_addr[15:8] <= rx_data;
                if (r_state == ST_ADDR_L) r_addr[7:0] <= rx_data;
                if (r_state == ST_LEN) r_len <= rx_data;
                if (r_state == ST_DATA_H) r_hi <= rx_data;
            end
            if (w_load) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_addr;
                r_mem_wdata <= {r_hi, rx_data};
                r_addr      <= r_addr + 16'd1;
                r_len       <= r_len - 8'd1;
            end else if (r_mem_we && mem_ready) begin
                r_mem_we <= 1'b0;
            end
        end
    end

    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;
    assign err_code    = r_err_code;
    assign busy        = (r_state != ST_IDLE) || r_mem_we;
endmodule
